// File: rtl/fib_alu_seq.sv
// Fibonacci sequencer driving a shared combinational ALU (ADD per term, SLTU wrap check).
// Optional FIB_SAT_EN: saturate the result to all-ones and finish early on the first wrap.
package micro_const_pkg;
    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SLTU = 4'b1000;
endpackage

module fib_alu_seq
    import micro_const_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [CNT_W-1:0]  n_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [DATA_W-1:0] result_o,
    output logic              ovf_o,
    output logic [3:0]        alu_op_o,
    output logic [DATA_W-1:0] alu_a_o,
    output logic [DATA_W-1:0] alu_b_o,
    input  logic [DATA_W-1:0] alu_y_i
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ADD  = 2'd1;
    localparam logic [1:0] S_CHK  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [DATA_W-1:0] f_prev_q, f_prev_d;
    logic [DATA_W-1:0] f_cur_q, f_cur_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  n_q, n_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic              ovf_q, ovf_d;

    assign busy_o   = (state_q != S_IDLE);
    assign done_o   = (state_q == S_DONE);
    assign result_o = result_q;
    assign ovf_o    = ovf_q;

    // ALU drive is decoded from registered state only.
    always_comb begin
        alu_op_o = ALU_ADD;
        alu_a_o  = '0;
        alu_b_o  = '0;
        case (state_q)
            S_ADD: begin
                alu_a_o = f_prev_q;
                alu_b_o = f_cur_q;
            end
            S_CHK: begin
                alu_op_o = ALU_SLTU;
                alu_a_o  = f_cur_q;
                alu_b_o  = f_prev_q;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        f_prev_d = f_prev_q;
        f_cur_d  = f_cur_q;
        cnt_d    = cnt_q;
        n_d      = n_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    n_d      = n_i;
                    f_prev_d = '0;
                    f_cur_d  = DATA_W'(1);
                    cnt_d    = CNT_W'(1);
                    ovf_d    = 1'b0;
                    if (n_i <= CNT_W'(1)) begin
                        state_d  = S_DONE;
                        result_d = (n_i == '0) ? '0 : DATA_W'(1);
                    end else begin
                        state_d = S_ADD;
                    end
                end
            end
            S_ADD: begin
                f_prev_d = f_cur_q;
                f_cur_d  = alu_y_i;
                cnt_d    = cnt_q + CNT_W'(1);
                state_d  = S_CHK;
            end
            S_CHK: begin
                if (alu_y_i[0])
                    ovf_d = 1'b1;
`ifdef FIB_SAT_EN
                if (alu_y_i[0]) begin
                    f_cur_d  = '1;
                    result_d = '1;
                    state_d  = S_DONE;
                end else if (cnt_q == n_q) begin
                    result_d = (n_q == '0) ? '0 : f_cur_q;
                    state_d  = S_DONE;
                end else begin
                    state_d = S_ADD;
                end
`else
                if (cnt_q == n_q) begin
                    result_d = (n_q == '0) ? '0 : f_cur_q;
                    state_d  = S_DONE;
                end else begin
                    state_d = S_ADD;
                end
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            f_prev_q <= '0;
            f_cur_q  <= '0;
            cnt_q    <= '0;
            n_q      <= '0;
            result_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            f_prev_q <= f_prev_d;
            f_cur_q  <= f_cur_d;
            cnt_q    <= cnt_d;
            n_q      <= n_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
        end
    end

endmodule

// File: tb/tb_fib_alu_seq.sv
// Scoreboard bench for fib_alu_seq: a 32-bit and an 8-bit instance, each with its own ALU model.
module tb_fib_alu_seq;

    typedef struct {
        logic [31:0] res;
        logic        ovf;
        int          cyc;
    } exp_t;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int          cyc;
    } alu_exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    exp_t     q32[$];
    exp_t     q8[$];
    alu_exp_t qa[$];

    logic        start32 = 1'b0, start8 = 1'b0;
    logic [5:0]  n32 = '0, n8 = '0;
    logic        busy32, done32, ovf32, busy8, done8, ovf8;
    logic [31:0] res32, a32, b32, y32;
    logic [7:0]  res8, a8, b8, y8;
    logic [3:0]  op32, op8;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference ALU: ADD = 0000, SLTU = 1000.
    assign y32 = (op32 == 4'b1000) ? {31'd0, a32 < b32} : (op32 == 4'b0000) ? a32 + b32 : '0;
    assign y8  = (op8  == 4'b1000) ? {7'd0,  a8  < b8 } : (op8  == 4'b0000) ? a8  + b8  : '0;

    fib_alu_seq #(.DATA_W(32), .CNT_W(6)) u32 (
        .clk(clk), .rst(rst), .start_i(start32), .n_i(n32),
        .busy_o(busy32), .done_o(done32), .result_o(res32), .ovf_o(ovf32),
        .alu_op_o(op32), .alu_a_o(a32), .alu_b_o(b32), .alu_y_i(y32)
    );

    fib_alu_seq #(.DATA_W(8), .CNT_W(6)) u8 (
        .clk(clk), .rst(rst), .start_i(start8), .n_i(n8),
        .busy_o(busy8), .done_o(done8), .result_o(res8), .ovf_o(ovf8),
        .alu_op_o(op8), .alu_a_o(a8), .alu_b_o(b8), .alu_y_i(y8)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!rst && done32) begin
            if (q32.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL done32_unexpected: got done_o=1, expected 0 (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = q32.pop_front();
                chk("res32", res32, e.res);
                chk("ovf32", {31'd0, ovf32}, {31'd0, e.ovf});
                chk("done32_cycle", cyc, e.cyc);
            end
        end
        if (!rst && done8) begin
            if (q8.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL done8_unexpected: got done_o=1, expected 0 (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = q8.pop_front();
                chk("res8", {24'd0, res8}, e.res);
                chk("ovf8", {31'd0, ovf8}, {31'd0, e.ovf});
                chk("done8_cycle", cyc, e.cyc);
            end
        end
        if (qa.size() > 0 && qa[0].cyc == cyc) begin
            alu_exp_t ae;
            ae = qa.pop_front();
            chk("alu_op32", {28'd0, op32}, {28'd0, ae.op});
            chk("alu_a32", a32, ae.a);
            chk("alu_b32", b32, ae.b);
        end
    end

    // lat < 0: no completion expected (run will be aborted by reset).
    task automatic run(input bit w8, input int n, input logic [31:0] er, input bit eo,
                       input int lat, input bit trace, output int t0);
        exp_t e;
        if (w8) begin n8 = 6'(n); start8 = 1'b1; end
        else    begin n32 = 6'(n); start32 = 1'b1; end
        t0 = cyc;
        if (lat >= 0) begin
            e.res = er; e.ovf = eo; e.cyc = t0 + lat;
            if (w8) q8.push_back(e); else q32.push_back(e);
        end
        if (trace) begin
            logic [31:0] fp, fc, nf;
            qa.push_back('{4'b0000, 32'd0, 32'd0, t0});
            fp = 0; fc = 1;
            for (int i = 1; i < n; i++) begin
                nf = fp + fc;
                qa.push_back('{4'b0000, fp, fc, t0 + 2*i - 1});
                qa.push_back('{4'b1000, nf, fc, t0 + 2*i});
                fp = fc; fc = nf;
            end
            qa.push_back('{4'b0000, 32'd0, 32'd0, t0 + ((n <= 1) ? 1 : 2*n - 1)});
        end
        tick();
        start8 = 1'b0;
        start32 = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && (q8.size() + q32.size() + qa.size()) != 0; i++)
            tick();
        chk("drain_pending", q8.size() + q32.size() + qa.size(), 0);
        repeat (4) tick();
    endtask

    int t;

    initial begin
        repeat (3) tick();
        rst = 1'b0;
        chk("rst_busy32", {31'd0, busy32}, 0);
        chk("rst_done32", {31'd0, done32}, 0);
        chk("rst_res32", res32, 0);
        chk("rst_ovf32", {31'd0, ovf32}, 0);
        chk("rst_op32", {28'd0, op32}, 0);
        chk("rst_a32", a32, 0);
        chk("rst_b32", b32, 0);
        chk("rst_busy8", {31'd0, busy8}, 0);
        chk("rst_res8", {24'd0, res8}, 0);
        tick();

        run(1'b0, 0, 32'd0, 1'b0, 1, 1'b1, t);  drain();
        run(1'b0, 1, 32'd1, 1'b0, 1, 1'b1, t);  drain();
        run(1'b0, 10, 32'd55, 1'b0, 19, 1'b1, t); drain();

        // Starts during ADD, CHK and DONE of an n=13 run must be ignored.
        run(1'b1, 13, 32'd233, 1'b0, 25, 1'b0, t);
        start8 = 1'b1; n8 = 6'd3;
        tick();
        tick();
        start8 = 1'b0;
        while (cyc < t + 25) tick();
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        drain();
        chk("hold_res8", {24'd0, res8}, 32'd233);

`ifdef FIB_SAT_EN
        run(1'b1, 14, 32'hFF, 1'b1, 27, 1'b0, t); drain();
        run(1'b1, 20, 32'hFF, 1'b1, 27, 1'b0, t); drain();
`else
        run(1'b1, 14, 32'd121, 1'b1, 27, 1'b0, t); drain();
        run(1'b1, 20, 32'd109, 1'b1, 39, 1'b0, t); drain();
`endif

        // Reset lands on the first CHK cycle (T+2) of an n=10 run.
        run(1'b0, 10, 32'd0, 1'b0, -1, 1'b0, t);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_busy32", {31'd0, busy32}, 0);
        chk("mid_rst_done32", {31'd0, done32}, 0);
        chk("mid_rst_res32", res32, 0);
        chk("mid_rst_ovf32", {31'd0, ovf32}, 0);
        chk("mid_rst_op32", {28'd0, op32}, 0);
        chk("mid_rst_a32", a32, 0);
        chk("mid_rst_b32", b32, 0);
        repeat (25) tick();
        run(1'b0, 5, 32'd5, 1'b0, 9, 1'b0, t); drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
